// File: rtl/mod_start_requester.sv
// Start/done handshake initiator: runs a batch of level start/done
// transfers. Optional REQ timeout abort enabled by MOD_START_REQ_TIMEOUT_EN.
module mod_start_requester #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_start,
    input  logic             i_done,
    output logic             o_busy,
    output logic             o_complete,
    output logic             o_err,
    output logic [CNT_W-1:0] o_done_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = o_done_cnt + CNT_W'(1);

`ifdef MOD_START_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign o_err = err_q;

    // Batch FSM with REQ watchdog; a transfer wins over the abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            count_q    <= '0;
            o_done_cnt <= '0;
            err_q      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_req) begin
                        o_done_cnt <= '0;
                        err_q      <= 1'b0;
                        tmo_cnt    <= '0;
                        count_q    <= i_count;
                        state      <= (i_count == '0) ? S_FIN : S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_done) begin
                        o_done_cnt <= cnt_inc;
                        state      <= (cnt_inc == count_q) ? S_FIN : S_GAP;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    tmo_cnt <= '0;
                    state   <= S_REQ;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
`else
    assign o_err = 1'b0;

    // Batch FSM; REQ waits for the responder indefinitely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            count_q    <= '0;
            o_done_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_req) begin
                        o_done_cnt <= '0;
                        count_q    <= i_count;
                        state      <= (i_count == '0) ? S_FIN : S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_done) begin
                        o_done_cnt <= cnt_inc;
                        state      <= (cnt_inc == count_q) ? S_FIN : S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_REQ;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
`endif

    assign o_start    = (state == S_REQ);
    assign o_busy     = (state != S_IDLE);
    assign o_complete = (state == S_FIN);

endmodule

// File: tb/tb_mod_start_requester.sv
// Directed bench for mod_start_requester.
// Responder mode: 0 manual, 1 combinational, 2 two-cycle delay.
module tb_mod_start_requester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] cnt = '0;
    logic       start;
    logic       done;
    logic       busy;
    logic       complete;
    logic       err;
    logic [7:0] done_cnt;

    int   checks = 0;
    int   failures = 0;
    int   mode = 0;
    logic done_drv = 1'b0;
    int   run_cnt;

    always #5 clk = ~clk;

    mod_start_requester #(
        .CNT_W  (8),
        .TIMEOUT(16)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_count   (cnt),
        .o_start   (start),
        .i_done    (done),
        .o_busy    (busy),
        .o_complete(complete),
        .o_err     (err),
        .o_done_cnt(done_cnt)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_cnt <= 0;
        else run_cnt <= start ? run_cnt + 1 : 0;
    end

    always_comb begin
        done = done_drv;
        if (mode == 1) done = start;
        else if (mode == 2) done = start && (run_cnt >= 2);
    end

    task automatic issue(input logic [7:0] n);
        @(negedge clk);
        req = 1'b1;
        cnt = n;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (start !== 1'b0) begin
            failures++;
            $display("FAIL reset_start got=%b exp=0", start);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (complete !== 1'b0) begin
            failures++;
            $display("FAIL reset_complete got=%b exp=0", complete);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0", err);
        end
        checks++;
        if (done_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", done_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb;
        logic es, ec, eb;
        mode = 1;
        issue(8'd3);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            es = (c == 1) || (c == 3) || (c == 5);
            ec = (c == 6);
            eb = (c <= 6);
            checks++;
            if ({start, complete, busy} !== {es, ec, eb}) begin
                failures++;
                $display("FAIL comb_c%0d got=%b%b%b exp=%b%b%b",
                         c, start, complete, busy, es, ec, eb);
            end
        end
        checks++;
        if (done_cnt !== 8'd3) begin
            failures++;
            $display("FAIL comb_cnt got=%0d exp=3", done_cnt);
        end
    endtask

    task automatic test_delay;
        logic es, ec, eb;
        mode = 2;
        issue(8'd2);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            es = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
            ec = (c == 8);
            eb = (c <= 8);
            checks++;
            if ({start, complete, busy} !== {es, ec, eb}) begin
                failures++;
                $display("FAIL delay_c%0d got=%b%b%b exp=%b%b%b",
                         c, start, complete, busy, es, ec, eb);
            end
        end
        checks++;
        if (done_cnt !== 8'd2) begin
            failures++;
            $display("FAIL delay_cnt got=%0d exp=2", done_cnt);
        end
    endtask

    task automatic test_zero;
        logic es, ec, eb;
        mode = 1;
        issue(8'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            es = 1'b0;
            ec = (c == 1);
            eb = (c == 1);
            checks++;
            if ({start, complete, busy} !== {es, ec, eb}) begin
                failures++;
                $display("FAIL zero_c%0d got=%b%b%b exp=%b%b%b",
                         c, start, complete, busy, es, ec, eb);
            end
        end
        checks++;
        if (done_cnt !== 8'd0) begin
            failures++;
            $display("FAIL zero_cnt got=%0d exp=0", done_cnt);
        end
    endtask

    task automatic test_held_req;
        logic es, ec, eb;
        mode = 1;
        @(negedge clk);
        req = 1'b1;
        cnt = 8'd2;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            es = (c == 1) || (c == 3) || (c == 6) || (c == 8);
            ec = (c == 4) || (c == 9);
            eb = (c <= 4) || (c >= 6 && c <= 9);
            checks++;
            if ({start, complete, busy} !== {es, ec, eb}) begin
                failures++;
                $display("FAIL held_c%0d got=%b%b%b exp=%b%b%b",
                         c, start, complete, busy, es, ec, eb);
            end
            if (c == 6) req = 1'b0;
        end
        checks++;
        if (done_cnt !== 8'd2) begin
            failures++;
            $display("FAIL held_cnt got=%0d exp=2", done_cnt);
        end
    endtask

    task automatic test_reset_mid_gap;
        logic es, ec;
        mode = 1;
        issue(8'd4);
        for (int c = 1; c <= 4; c++) @(negedge clk);
        checks++;
        if ({start, busy, done_cnt} !== {1'b0, 1'b1, 8'd2}) begin
            failures++;
            $display("FAIL gap_pre got=%b%b cnt=%0d exp=01 cnt=2",
                     start, busy, done_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({start, busy, complete, err, done_cnt} !== 12'd0) begin
            failures++;
            $display("FAIL gap_rst got=%b%b%b%b cnt=%0d exp=0000 cnt=0",
                     start, busy, complete, err, done_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            es = (c == 1) || (c == 3) || (c == 5) || (c == 7);
            ec = (c == 8);
            checks++;
            if ({start, complete} !== {es, ec}) begin
                failures++;
                $display("FAIL rerun_c%0d got=%b%b exp=%b%b",
                         c, start, complete, es, ec);
            end
        end
        checks++;
        if (done_cnt !== 8'd4) begin
            failures++;
            $display("FAIL rerun_cnt got=%0d exp=4", done_cnt);
        end
    endtask

`ifdef MOD_START_REQ_TIMEOUT_EN
    task automatic test_timeout;
        logic es, ec, ee;
        mode = 0;
        done_drv = 1'b0;
        issue(8'd5);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            es = (c <= 16);
            ec = (c == 17);
            ee = (c >= 17);
            checks++;
            if ({start, complete, err} !== {es, ec, ee}) begin
                failures++;
                $display("FAIL tmo_c%0d got=%b%b%b exp=%b%b%b",
                         c, start, complete, err, es, ec, ee);
            end
        end
        checks++;
        if (done_cnt !== 8'd0) begin
            failures++;
            $display("FAIL tmo_cnt got=%0d exp=0", done_cnt);
        end
        issue(8'd5);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (err !== 1'b0) begin
                    failures++;
                    $display("FAIL tmo_errclr got=%b exp=0", err);
                end
            end
            if (c == 16) done_drv = 1'b1;
            if (c == 17) begin
                done_drv = 1'b0;
                checks++;
                if ({start, complete, err, done_cnt} !==
                    {1'b0, 1'b0, 1'b0, 8'd1}) begin
                    failures++;
                    $display("FAIL tmo_prec got=%b%b%b cnt=%0d exp=000 cnt=1",
                             start, complete, err, done_cnt);
                end
            end
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`else
    task automatic test_no_timeout;
        int bad;
        bad = 0;
        mode = 0;
        done_drv = 1'b0;
        issue(8'd5);
        repeat (1000) begin
            @(negedge clk);
            if (start !== 1'b1 || complete !== 1'b0 || err !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL notmo_stuck got=%0d bad cycles exp=0", bad);
        end
        checks++;
        if (done_cnt !== 8'd0) begin
            failures++;
            $display("FAIL notmo_cnt got=%0d exp=0", done_cnt);
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_comb();
        test_delay();
        test_zero();
        test_held_req();
        test_reset_mid_gap();
`ifdef MOD_START_REQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_start_requester.md
# mod_start_requester

Initiator side of the level start/done handshake: accepts a batch request, drives `o_start` toward a downstream start/done responder, and counts completed transfers until the batch length is reached. It sits upstream of any responder whose `o_done` may follow `i_start` combinationally or several cycles later. It reports completion with a one-cycle pulse, a live transfer count and an optional timeout error.

## Interface
- `CNT_W`, 8: width of batch length and completion counter.
- `TIMEOUT`, 16: maximum consecutive REQ cycles without `i_done` before abort (≥1; used only with timeout enabled).

- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_req` in 1: batch request, sampled in IDLE only.
- `i_count` in CNT_W: batch length, latched with `i_req`.
- `o_start` out 1: start level to responder.
- `i_done` in 1: responder done level.
- `o_busy` out 1: high in any state except IDLE.
- `o_complete` out 1: one-cycle pulse at batch end.
- `o_err` out 1: batch aborted by timeout; sticky until next accepted request.
- `o_done_cnt` out CNT_W: transfers completed in the current or last batch.

## Operation
- All outputs registered or decoded from registered state. Reset value of every output is 0; state = IDLE.
- States:
  - IDLE: `o_busy`=0.
  - REQ: `o_start`=1.
  - GAP: `o_start`=0.
  - FIN: `o_complete`=1.
- IDLE:
  - `i_req`=1 and `i_count`≠0: latch count, clear `o_done_cnt` and `o_err`, go to REQ.
  - `i_req`=1 and `i_count`=0: clear `o_done_cnt` and `o_err`, go to FIN. No start is issued.
- REQ: a transfer occurs on any cycle with `o_start`=1 and `i_done`=1.
  - On a transfer, `o_done_cnt` increments.
  - If the new count equals the latched count, go to FIN; otherwise go to GAP.
  - No transfer: stay in REQ.
- GAP: one cycle, then REQ. This guarantees `o_start` deasserts between transfers.
- FIN: one cycle, then IDLE.
- `i_done` outside REQ is ignored. `i_req` while busy is ignored; it is not queued.
- `o_done_cnt` holds its value in IDLE after a batch. Count arithmetic is CNT_W-bit unsigned. Wrap cannot occur because the batch ends at the latched count.
- Asynchronous reset mid-batch returns to IDLE immediately with all outputs 0. The partial count is lost.

## Timing
- `i_req` sampled at edge 0 → `o_start` high in cycle 1.
- With a combinational responder (`i_done`=`o_start`), transfers occur in cycles 1, 3, 5, …, and `o_complete` pulses in cycle 2N for batch length N. `o_busy` is high in cycles 1..2N and IDLE is re-entered in cycle 2N+1.
- A responder latency of L cycles adds L cycles per transfer.
- Earliest next accepted `i_req`: the edge ending cycle 2N+1.
- `i_count`=0: `o_complete` pulses in cycle 1 with `o_busy`=1 and no `o_start`.

## Configuration
- `MOD_START_REQ_TIMEOUT_EN` defined:
  - A cycle counter of width `$clog2(TIMEOUT+1)` runs in REQ while `i_done`=0 and clears on entry to REQ.
  - After TIMEOUT consecutive REQ cycles without a transfer, go to FIN with `o_err`=1. `o_done_cnt` keeps its partial value.
  - A transfer in the TIMEOUT-th cycle takes precedence over the abort.
- Not defined: no counter and no abort logic. REQ waits indefinitely. `o_err` is tied to 0.

## Test plan
- Combinational responder, `i_count`=3 → `o_start` high in cycles 1, 3, 5; `o_complete` in cycle 6; `o_done_cnt`=3.
- Responder with 2-cycle done delay, `i_count`=2 → each REQ lasts 3 cycles with one GAP between; `o_complete` pulses once; count=2.
- `i_count`=0 → `o_complete` in cycle 1; `o_start` never high; count=0.
- `i_req` held high throughout a batch → exactly one batch executes; the next batch starts in IDLE after FIN.
- Reset asserted in the middle of a GAP cycle of a 4-transfer batch → all outputs 0 asynchronously; the next `i_req` runs a full batch from count 0.
- Macro defined, TIMEOUT=16, `i_done` stuck at 0, `i_count`=5 → FIN after 16 REQ cycles with `o_err`=1 and count=0. Without the macro, the block stays in REQ for 1000 cycles.
